// File: rtl/eight_queen_board_checker_if.sv
// rtl/eight_queen_board_checker_if.sv - column stream, verdict and counter signals of the N-queen board checker
interface eight_queen_board_checker_if #(
    parameter int N     = 8,
    parameter int CNT_W = 7
);
    logic             in_valid;
    logic             in_first;
    logic [N-1:0]     in_data;
    logic             in_ready;
    logic             result_valid;
    logic             result_ok;
    logic             result_ack;
    logic [CNT_W-1:0] sol_count;
    logic             sol_clear;

    modport master (
        output in_valid, in_first, in_data, result_ack, sol_clear,
        input  in_ready, result_valid, result_ok, sol_count
    );

    modport slave (
        input  in_valid, in_first, in_data, result_ack, sol_clear,
        output in_ready, result_valid, result_ok, sol_count
    );
endinterface

// File: rtl/eight_queen_board_checker.sv
// rtl/eight_queen_board_checker.sv - on-the-fly N-queen legality checker with saturating legal-board count
// Optional macro EQ_FAIL_INFO_EN adds fail_col/fail_kind outputs describing the first error.
module eight_queen_board_checker #(
    parameter int N     = 8,
    parameter int CNT_W = 7
) (
    input  logic                          clk,
    input  logic                          reset,
    eight_queen_board_checker_if.slave    bus
`ifdef EQ_FAIL_INFO_EN
    ,
    output logic [2:0]                    fail_col,
    output logic [1:0]                    fail_kind
`endif
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_REPORT} state_t;

    state_t           state, next_state;
    logic [N-1:0]     rows, dl, dr;
    logic [CW-1:0]    col;
    logic             fail;
    logic             result_ok;
    logic [CNT_W-1:0] sol_count;

    logic             accept, start, take, last;
    logic [N-1:0]     rows_b, dl_b, dr_b;
    logic [CW-1:0]    col_cur;
    logic             fail_b, onehot_err, row_err, diag_err, col_err, board_fail, inc;

    // A byte with in_first always re-seeds the accumulators, even mid-board.
    always_comb begin
        accept     = bus.in_valid && (state != S_REPORT);
        start      = accept && bus.in_first;
        take       = start || (accept && (state == S_COLLECT));
        rows_b     = start ? '0 : rows;
        dl_b       = start ? '0 : dl;
        dr_b       = start ? '0 : dr;
        col_cur    = start ? '0 : col;
        fail_b     = start ? 1'b0 : fail;
        onehot_err = (bus.in_data == '0) || ((bus.in_data & (bus.in_data - N'(1))) != '0);
        row_err    = |(bus.in_data & rows_b);
        diag_err   = |(bus.in_data & (dl_b | dr_b));
        col_err    = onehot_err || row_err || diag_err;
        board_fail = fail_b || col_err;
        last       = (col_cur == CW'(N - 1));
        inc        = take && last && !board_fail;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_COLLECT: if (take) next_state = last ? S_REPORT : S_COLLECT;
            S_REPORT:          if (bus.result_ack) next_state = S_IDLE;
            default:           next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= next_state;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rows      <= '0;
            dl        <= '0;
            dr        <= '0;
            col       <= '0;
            fail      <= 1'b0;
            result_ok <= 1'b0;
        end else if (take) begin
            rows <= rows_b | bus.in_data;
            dl   <= (dl_b | bus.in_data) << 1;
            dr   <= (dr_b | bus.in_data) >> 1;
            col  <= col_cur + CW'(1);
            fail <= board_fail;
            if (last) result_ok <= !board_fail;
        end else if (state == S_REPORT && bus.result_ack) begin
            result_ok <= 1'b0;
        end
    end

    // Clear has priority over a coincident increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                  sol_count <= '0;
        else if (bus.sol_clear)      sol_count <= '0;
        else if (inc && !(&sol_count)) sol_count <= sol_count + CNT_W'(1);
    end

`ifdef EQ_FAIL_INFO_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fail_col  <= '0;
            fail_kind <= '0;
        end else if (take) begin
            if (col_err && !fail_b) begin
                fail_col  <= 3'(col_cur);
                fail_kind <= onehot_err ? 2'b01 : (row_err ? 2'b10 : 2'b11);
            end else if (start) begin
                fail_col  <= '0;
                fail_kind <= '0;
            end
        end
    end
`endif

    assign bus.in_ready     = (state != S_REPORT);
    assign bus.result_valid = (state == S_REPORT);
    assign bus.result_ok    = result_ok;
    assign bus.sol_count    = sol_count;
endmodule

// File: tb/tb_eight_queen_board_checker.sv
// tb/tb_eight_queen_board_checker.sv - scoreboard bench for eight_queen_board_checker (directed boards)
module tb_eight_queen_board_checker;
    typedef struct packed {
        logic       ok;
        logic [2:0] col;
        logic [1:0] kind;
    } exp_t;

    localparam logic [63:0] LEGAL = 64'h01_10_80_20_04_40_02_08;
    localparam logic [63:0] ROWC  = 64'h01_01_10_80_20_04_40_02;
    localparam logic [63:0] DIAGC = 64'h01_02_80_20_04_40_10_08;
    localparam logic [63:0] ZEROB = 64'h01_10_80_00_04_40_02_08;

    logic clk = 1'b0;
    logic rst_n;
    logic hold_ack = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   exp_count = 0;
    exp_t exp_q[$];

    eight_queen_board_checker_if #(.N(8), .CNT_W(7)) bus ();

`ifdef EQ_FAIL_INFO_EN
    logic [2:0] fail_col;
    logic [1:0] fail_kind;
    eight_queen_board_checker #(.N(8), .CNT_W(7)) dut (
        .clk(clk), .reset(rst_n), .bus(bus.slave),
        .fail_col(fail_col), .fail_kind(fail_kind));
`else
    eight_queen_board_checker #(.N(8), .CNT_W(7)) dut (
        .clk(clk), .reset(rst_n), .bus(bus.slave));
`endif

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic ok, input logic [2:0] c, input logic [1:0] k);
        exp_t e;
        e.ok = ok; e.col = c; e.kind = k;
        exp_q.push_back(e);
        if (ok) exp_count = (exp_count == 127) ? 127 : exp_count + 1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic first);
        bit accepted = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_first = first;
        for (int t = 0; t < 200; t++) begin
            if (bus.in_ready) begin
                @(posedge clk);
                accepted = 1;
                break;
            end
            @(negedge clk);
        end
        if (!accepted) check("send_timeout", 0, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
    endtask

    task automatic send_cols(input logic [63:0] b, input int n);
        for (int i = 0; i < n; i++) send_byte(b[63-8*i -: 8], i == 0);
    endtask

    task automatic wait_drain();
        bit done = 0;
        for (int t = 0; t < 400; t++) begin
            if (exp_q.size() == 0 && !bus.result_valid) begin
                done = 1;
                break;
            end
            @(negedge clk);
        end
        if (!done) check("drain_timeout", 0, 1);
    endtask

    // Monitor: pops the oldest expectation whenever a verdict is presented.
    initial begin
        exp_t e;
        bus.result_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.result_valid === 1'b1 && !hold_ack) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_verdict", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("result_ok", 32'(bus.result_ok), 32'(e.ok));
`ifdef EQ_FAIL_INFO_EN
                    check("fail_col", 32'(fail_col), 32'(e.col));
                    check("fail_kind", 32'(fail_kind), 32'(e.kind));
`endif
                end
                bus.result_ack = 1'b1;
                @(negedge clk);
                bus.result_ack = 1'b0;
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        bus.in_data  = '0;
        bus.sol_clear = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check("rst_result_valid", 32'(bus.result_valid), 0);
        check("rst_sol_count", 32'(bus.sol_count), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // stray byte without in_first is dropped in IDLE
        send_byte(8'h04, 1'b0);
        push_exp(1'b1, 3'd0, 2'b00);
        send_cols(LEGAL, 8);
        check("latency_valid", 32'(bus.result_valid), 1);
        check("count_after_legal", 32'(bus.sol_count), 1);
        wait_drain();

        push_exp(1'b0, 3'd1, 2'b10);
        send_cols(ROWC, 8);
        wait_drain();
        push_exp(1'b0, 3'd1, 2'b11);
        send_cols(DIAGC, 8);
        wait_drain();
        push_exp(1'b0, 3'd3, 2'b01);
        send_cols(ZEROB, 8);
        wait_drain();
        check("count_after_fails", 32'(bus.sol_count), 32'(exp_count));

        // abandon at column 5, restart with a full legal board
        send_cols(LEGAL, 5);
        push_exp(1'b1, 3'd0, 2'b00);
        send_cols(LEGAL, 8);
        wait_drain();
        check("count_after_abort", 32'(bus.sol_count), 32'(exp_count));

        // verdict held while unacknowledged; offered bytes not taken
        hold_ack = 1'b1;
        push_exp(1'b1, 3'd0, 2'b00);
        send_cols(LEGAL, 8);
        bus.in_valid = 1'b1; bus.in_first = 1'b1; bus.in_data = 8'h01;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(bus.result_valid), 1);
            check("hold_ready", 32'(bus.in_ready), 0);
        end
        bus.in_valid = 1'b0; bus.in_first = 1'b0;
        hold_ack = 1'b0;
        wait_drain();
        check("ready_after_ack", 32'(bus.in_ready), 1);
        check("count_after_hold", 32'(bus.sol_count), 32'(exp_count));

        // clear coinciding with increment: clear wins
        push_exp(1'b1, 3'd0, 2'b00);
        send_cols(LEGAL, 7);
        bus.sol_clear = 1'b1;
        send_byte(LEGAL[7:0], 1'b0);
        bus.sol_clear = 1'b0;
        exp_count = 0;
        check("clear_wins", 32'(bus.sol_count), 0);
        wait_drain();

        for (int b = 0; b < 127; b++) begin
            push_exp(1'b1, 3'd0, 2'b00);
            send_cols(LEGAL, 8);
        end
        wait_drain();
        check("count_127", 32'(bus.sol_count), 127);
        push_exp(1'b1, 3'd0, 2'b00);
        send_cols(LEGAL, 8);
        wait_drain();
        check("count_saturated", 32'(bus.sol_count), 127);
        bus.sol_clear = 1'b1;
        @(negedge clk);
        bus.sol_clear = 1'b0;
        exp_count = 0;
        check("count_cleared", 32'(bus.sol_count), 0);

        push_exp(1'b1, 3'd0, 2'b00);
        send_cols(LEGAL, 8);
        wait_drain();
        send_cols(ROWC, 3);
        rst_n = 1'b0;
        #1;
        check("midrst_sol_count", 32'(bus.sol_count), 0);
        check("midrst_valid", 32'(bus.result_valid), 0);
        check("midrst_ok", 32'(bus.result_ok), 0);
        check("midrst_ready", 32'(bus.in_ready), 1);
        exp_count = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_exp(1'b1, 3'd0, 2'b00);
        send_cols(LEGAL, 8);
        wait_drain();
        check("count_after_reset", 32'(bus.sol_count), 1);
        push_exp(1'b0, 3'd1, 2'b11);
        send_cols(DIAGC, 8);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
